// File: rtl/mem_arbiter_if.sv
// Signal bundle between the arbiter, its fetch and load/store requesters and the
// shared single-port memory. The arbiter takes the slave view; the environment the master view.
interface mem_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  if_req;
  logic [ADDR_WIDTH-1:0] if_addr;
  logic                  if_ack;
  logic                  if_rvalid;
  logic [DATA_WIDTH-1:0] if_rdata;

  logic                  dm_req;
  logic                  dm_we;
  logic [3:0]            dm_be;
  logic [ADDR_WIDTH-1:0] dm_addr;
  logic [DATA_WIDTH-1:0] dm_wdata;
  logic                  dm_ack;
  logic                  dm_rvalid;
  logic [DATA_WIDTH-1:0] dm_rdata;

  logic                  mem_en;
  logic                  mem_we;
  logic [3:0]            mem_be;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;

  logic                  busy;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_be, dm_addr, dm_wdata, mem_rdata,
    output if_ack, if_rvalid, if_rdata, dm_ack, dm_rvalid, dm_rdata,
           mem_en, mem_we, mem_be, mem_addr, mem_wdata, busy
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_be, dm_addr, dm_wdata, mem_rdata,
    input  if_ack, if_rvalid, if_rdata, dm_ack, dm_rvalid, dm_rdata,
           mem_en, mem_we, mem_be, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates one single-port memory between instruction fetch and load/store:
// one transaction at a time, data-first with a bounded run so fetch always progresses.
module mem_arbiter #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int MEM_LATENCY = 2,
  parameter int MAX_DM_RUN  = 4
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [3:0] RUN_MAX  = 4'(MAX_DM_RUN);
  localparam logic [2:0] LAT_INIT = 3'(MEM_LATENCY - 1);

  state_t                state_q, state_d;
  logic [3:0]            run_q, run_d;
  logic [2:0]            lat_q, lat_d;
  logic                  owner_dm_q, owner_dm_d;
  logic                  cmd_we_q, cmd_we_d;
  logic [3:0]            cmd_be_q, cmd_be_d;
  logic [ADDR_WIDTH-1:0] cmd_addr_q, cmd_addr_d;
  logic [DATA_WIDTH-1:0] cmd_wdata_q, cmd_wdata_d;
  logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_WIDTH-1:0] dm_rdata_q, dm_rdata_d;
  logic                  grant_dm, grant_if;

  // Data wins unless it has already taken MAX_DM_RUN grants in a row while fetch waits.
  always_comb begin
    grant_dm = 1'b0;
    grant_if = 1'b0;
    if (state_q == IDLE && !rst) begin
      grant_dm = bus.dm_req && !(bus.if_req && run_q == RUN_MAX);
      grant_if = bus.if_req && !grant_dm;
    end
  end

  always_comb begin
    state_d     = state_q;
    run_d       = run_q;
    lat_d       = lat_q;
    owner_dm_d  = owner_dm_q;
    cmd_we_d    = cmd_we_q;
    cmd_be_d    = cmd_be_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_wdata_d = cmd_wdata_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    case (state_q)
      IDLE: begin
        if (grant_dm || grant_if) begin
          owner_dm_d = grant_dm;
          cmd_we_d   = grant_dm && bus.dm_we;
          cmd_be_d   = (grant_dm && bus.dm_we) ? bus.dm_be : 4'hF;
          cmd_addr_d = grant_dm ? bus.dm_addr : bus.if_addr;
          if (grant_dm) begin
            cmd_wdata_d = bus.dm_wdata;
          end
          if (grant_dm) begin
            run_d = (run_q == RUN_MAX) ? run_q : run_q + 4'd1;
          end else begin
            run_d = 4'd0;
          end
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (cmd_we_q) begin
          state_d = RESP;
        end else begin
          lat_d   = LAT_INIT;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (lat_q == 3'd0) begin
          if (owner_dm_q) begin
            dm_rdata_d = bus.mem_rdata;
          end else begin
            if_rdata_d = bus.mem_rdata;
          end
          state_d = RESP;
        end else begin
          lat_d = lat_q - 3'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      run_q       <= '0;
      lat_q       <= '0;
      owner_dm_q  <= 1'b0;
      cmd_we_q    <= 1'b0;
      cmd_be_q    <= '0;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      run_q       <= run_d;
      lat_q       <= lat_d;
      owner_dm_q  <= owner_dm_d;
      cmd_we_q    <= cmd_we_d;
      cmd_be_q    <= cmd_be_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_wdata_q <= cmd_wdata_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
    end
  end

  // The command registers double as the memory bus, so mem_* hold between strobes.
  assign bus.if_ack    = grant_if;
  assign bus.dm_ack    = grant_dm;
  assign bus.mem_en    = (state_q == ISSUE);
  assign bus.mem_we    = cmd_we_q;
  assign bus.mem_be    = cmd_be_q;
  assign bus.mem_addr  = cmd_addr_q;
  assign bus.mem_wdata = cmd_wdata_q;
  assign bus.if_rvalid = (state_q == RESP) && !owner_dm_q;
  assign bus.dm_rvalid = (state_q == RESP) && owner_dm_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.dm_rdata  = dm_rdata_q;
  assign bus.busy      = (state_q != IDLE);
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a transaction-timeline model (cycles since ack, grant history)
// predicts every output each cycle; a second instance covers single-cycle memory latency.
module tb_mem_arbiter;
  localparam int DW   = 32;
  localparam int AW   = 32;
  localparam int LAT  = 2;
  localparam int MAXR = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  mem_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();
  mem_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus1 ();

  mem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_LATENCY(LAT), .MAX_DM_RUN(MAXR)) u_dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  mem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_LATENCY(1), .MAX_DM_RUN(MAXR)) u_dut1 (
    .clk(clk), .rst(rst), .bus(bus1)
  );

  // Memory: read data appears exactly LAT cycles after the strobe, junk otherwise.
  logic [31:0]    mem_arr [128];
  logic [LAT-1:0] pipe_v = '0;
  logic [31:0]    pipe_d [LAT];
  logic [31:0]    junk = 32'h0BAD_F00D;

  always @(posedge clk) begin
    junk <= $urandom;
    for (int i = LAT - 1; i > 0; i--) begin
      pipe_v[i] <= pipe_v[i-1];
      pipe_d[i] <= pipe_d[i-1];
    end
    pipe_v[0] <= bus.mem_en && !bus.mem_we;
    pipe_d[0] <= mem_arr[bus.mem_addr[8:2]];
    if (bus.mem_en && bus.mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.mem_be[b]) mem_arr[bus.mem_addr[8:2]][8*b +: 8] = bus.mem_wdata[8*b +: 8];
      end
    end
  end
  assign bus.mem_rdata = pipe_v[LAT-1] ? pipe_d[LAT-1] : junk;

  // Reference model: k = index of the current cycle counted from the ack cycle (-1 = idle).
  int          k = -1;
  bit          cur_dm, cur_we;
  logic [3:0]  cur_be;
  logic [31:0] cur_addr, cur_wdata, cur_rdata;
  logic [31:0] exp_if_rdata = '0;
  logic [31:0] exp_dm_rdata = '0;
  bit          exp_if_ack, exp_dm_ack;
  bit          hist[$];
  int          n_grants = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int trailing_data();
    int n = 0;
    for (int i = hist.size() - 1; i >= 0; i--) begin
      if (!hist[i]) break;
      n++;
    end
    return n;
  endfunction

  function automatic int done_cycle();
    return cur_we ? 2 : LAT + 2;
  endfunction

  task automatic check_outputs();
    exp_if_ack = 1'b0;
    exp_dm_ack = 1'b0;
    if (rst) return;
    if (k == -1) begin
      exp_dm_ack = bus.dm_req && !(bus.if_req && trailing_data() >= MAXR);
      exp_if_ack = bus.if_req && !exp_dm_ack;
    end
    chk("if_ack", bus.if_ack, exp_if_ack);
    chk("dm_ack", bus.dm_ack, exp_dm_ack);
    chk("busy", bus.busy, k >= 1);
    chk("mem_en", bus.mem_en, k == 1);
    if (k == 1) begin
      chk("mem_we", bus.mem_we, cur_we);
      chk("mem_be", bus.mem_be, cur_be);
      chk("mem_addr", bus.mem_addr, cur_addr);
      if (cur_we) chk("mem_wdata", bus.mem_wdata, cur_wdata);
    end
    chk("if_rvalid", bus.if_rvalid, k == done_cycle() && !cur_dm);
    chk("dm_rvalid", bus.dm_rvalid, k == done_cycle() && cur_dm);
    chk("if_rdata", bus.if_rdata, exp_if_rdata);
    chk("dm_rdata", bus.dm_rdata, exp_dm_rdata);
  endtask

  task automatic advance();
    if (rst) begin
      k = -1;
      exp_if_rdata = '0;
      exp_dm_rdata = '0;
      hist.delete();
      return;
    end
    if (k == -1) begin
      if (exp_dm_ack || exp_if_ack) begin
        cur_dm    = exp_dm_ack;
        cur_addr  = cur_dm ? bus.dm_addr : bus.if_addr;
        cur_we    = cur_dm && bus.dm_we;
        cur_be    = cur_we ? bus.dm_be : 4'hF;
        cur_wdata = bus.dm_wdata;
        cur_rdata = mem_arr[cur_addr[8:2]];
        hist.push_back(cur_dm);
        n_grants++;
        k = 1;
      end
    end else if (k == done_cycle()) begin
      k = -1;
    end else begin
      k++;
      if (!cur_we && k == done_cycle()) begin
        if (cur_dm) exp_dm_rdata = cur_rdata;
        else        exp_if_rdata = cur_rdata;
      end
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    advance();
    #1;
  endtask

  task automatic request(input bit f, input bit d, input bit we, input logic [3:0] be,
                         input logic [31:0] fa, input logic [31:0] da, input logic [31:0] wd,
                         input int linger);
    int start;
    start = n_grants;
    bus.if_req = f;  bus.if_addr = fa;
    bus.dm_req = d;  bus.dm_we = we;  bus.dm_be = be;  bus.dm_addr = da;  bus.dm_wdata = wd;
    for (int i = 0; i < 40 && n_grants == start; i++) cycle();
    if (n_grants != start) begin
      if (hist[hist.size()-1]) bus.dm_req = 1'b0;
      else                     bus.if_req = 1'b0;
    end
    repeat (linger) cycle();
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && k != -1; i++) cycle();
  endtask

  task automatic check_zero_bus(input string tag);
    chk({tag, "_mem_addr"}, bus.mem_addr, '0);
    chk({tag, "_mem_be"}, bus.mem_be, '0);
    chk({tag, "_mem_we"}, bus.mem_we, '0);
    chk({tag, "_mem_wdata"}, bus.mem_wdata, '0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    string order;
    int    start;
    bit    f, d;
    int    sel;

    for (int i = 0; i < 128; i++) mem_arr[i] = $urandom;
    mem_arr[4]  = 32'h0050_0093;
    mem_arr[64] = 32'h1234_5678;
    bus.if_req = 0; bus.if_addr = '0; bus.dm_req = 0; bus.dm_we = 0;
    bus.dm_be = '0; bus.dm_addr = '0; bus.dm_wdata = '0;
    bus1.if_req = 0; bus1.if_addr = '0; bus1.dm_req = 0; bus1.dm_we = 0;
    bus1.dm_be = '0; bus1.dm_addr = '0; bus1.dm_wdata = '0; bus1.mem_rdata = 32'h0BAD_0BAD;

    // Reset state
    repeat (2) cycle();
    rst = 1'b0;
    cycle();
    check_zero_bus("reset");

    // Fetch of 0x10 returning 0x00500093
    request(1, 0, 0, 4'h0, 32'h10, 32'h0, 32'h0, 0);
    drain();
    chk("fetch_word", bus.if_rdata, 32'h0050_0093);

    // Halfword-enable store, then read it back
    request(0, 1, 1, 4'b0011, 32'h0, 32'h100, 32'hDEAD_BEEF, 0);
    drain();
    request(0, 1, 0, 4'hF, 32'h0, 32'h100, 32'h0, 0);
    drain();
    chk("store_readback", bus.dm_rdata, 32'h1234_BEEF);

    // Data request raised while a fetch is in flight
    request(1, 0, 0, 4'h0, 32'h20, 32'h0, 32'h0, 0);
    request(0, 1, 0, 4'hF, 32'h0, 32'h24, 32'h0, 0);
    drain();

    // Both requesters held continuously, starting from a fresh run
    request(1, 0, 0, 4'h0, 32'h30, 32'h0, 32'h0, 0);
    drain();
    start = hist.size();
    bus.if_req = 1; bus.if_addr = 32'h40;
    bus.dm_req = 1; bus.dm_we = 0; bus.dm_be = 4'hF; bus.dm_addr = 32'h44;
    for (int i = 0; i < 200 && hist.size() < start + 10; i++) cycle();
    bus.if_req = 0; bus.dm_req = 0;
    drain();
    order = "DDDDFDDDDF";
    for (int i = 0; i < 10; i++) begin
      chk("grant_order", (start + i < hist.size()) ? (hist[start+i] ? "D" : "F") : "?", order[i]);
    end

    // Reset during the WAIT of a load
    request(0, 1, 0, 4'hF, 32'h0, 32'h48, 32'h0, 0);
    cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    repeat (4) cycle();
    check_zero_bus("midreset");
    chk("midreset_dm_rdata", bus.dm_rdata, '0);

    // Random traffic, including zero byte-enable stores and requests raised while busy
    for (int n = 0; n < 120; n++) begin
      sel = $urandom_range(0, 2);
      f = (sel != 1);
      d = (sel != 0);
      request(f, d, 1'($urandom_range(0, 1)),
              ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom),
              32'($urandom_range(0, 127)) << 2, 32'($urandom_range(0, 127)) << 2,
              $urandom, $urandom_range(0, 6));
    end
    bus.if_req = 0; bus.dm_req = 0;
    drain();
    cycle();

    // Single-cycle memory latency instance: load returning 0xA5A5A5A5
    bus1.dm_req = 1; bus1.dm_we = 0; bus1.dm_be = 4'hF; bus1.dm_addr = 32'h40;
    @(negedge clk);
    chk("l1_dm_ack", bus1.dm_ack, 1'b1);
    chk("l1_busy_t0", bus1.busy, 1'b0);
    @(posedge clk); #1;
    bus1.dm_req = 0; bus1.if_req = 1; bus1.if_addr = 32'h8;
    @(negedge clk);
    chk("l1_mem_en", bus1.mem_en, 1'b1);
    chk("l1_mem_addr", bus1.mem_addr, 32'h40);
    chk("l1_mem_be", bus1.mem_be, 4'hF);
    chk("l1_busy_t1", bus1.busy, 1'b1);
    chk("l1_if_ack_busy", bus1.if_ack, 1'b0);
    @(posedge clk); #1;
    bus1.mem_rdata = 32'hA5A5_A5A5;
    @(negedge clk);
    chk("l1_busy_t2", bus1.busy, 1'b1);
    chk("l1_rvalid_t2", bus1.dm_rvalid, 1'b0);
    chk("l1_mem_en_t2", bus1.mem_en, 1'b0);
    @(posedge clk); #1;
    bus1.mem_rdata = 32'h0BAD_0BAD;
    @(negedge clk);
    chk("l1_rvalid_t3", bus1.dm_rvalid, 1'b1);
    chk("l1_dm_rdata", bus1.dm_rdata, 32'hA5A5_A5A5);
    chk("l1_busy_t3", bus1.busy, 1'b1);
    chk("l1_if_ack_resp", bus1.if_ack, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("l1_busy_t4", bus1.busy, 1'b0);
    chk("l1_rvalid_t4", bus1.dm_rvalid, 1'b0);
    chk("l1_if_ack_idle", bus1.if_ack, 1'b1);
    chk("l1_dm_rdata_hold", bus1.dm_rdata, 32'hA5A5_A5A5);
    @(posedge clk); #1;
    bus1.if_req = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
